// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants, skid-buffer state encoding, write-back decode.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pipe_pkg;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_LOAD   = 4'h2;
   localparam logic [3:0] OP_STORE  = 4'h3;
   localparam logic [3:0] OP_BRANCH = 4'h4;

   // Occupancy of a two-entry skid buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Stores, branches and bubbles never write the register file.
   function automatic logic is_writeback(input logic [3:0] opcode);
      return !((opcode == OP_NOP) || (opcode == OP_STORE) || (opcode == OP_BRANCH));
   endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Generic two-entry valid/ready buffer with flush; the main register always holds the head entry.
// Latency: 1 cycle from in handshake to out_valid.
// Backpressure: in_ready is registered (low only when both slots are full); no combinational path from out_ready.
module skid_buffer2
   import pipe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   main_q;
   logic [W-1:0]   skid_q;
   logic           in_fire;
   logic           out_fire;
   logic           load_main_in;
   logic           load_skid_in;
   logic           promote_skid;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;

   // Next occupancy and which slot each handshake writes; flush overrides everything.
   always_comb begin
      state_nxt    = state;
      load_main_in = 1'b0;
      load_skid_in = 1'b0;
      promote_skid = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt    = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  state_nxt    = FULL;
                  load_skid_in = 1'b1;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_nxt    = ONE;
                  promote_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // State register; in_ready is precomputed from the next state so it is a pure flop output.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != FULL);
      end
   end

   // Payload slots; contents are left alone on flush since only occupancy defines validity.
   always_ff @(posedge clock) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_data;
         end else if (promote_skid) begin
            main_q <= skid_q;
         end
         if (load_skid_in) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: skid-buffered capture of ALU/memory results with write-back select and write-enable decode.
// Latency: 1 cycle; one entry per cycle while out_ready is high. Optional retire counter via MEM_WB_STATS_EN.
// Backpressure: holds up to two entries; in_ready (registered) drops only when both are occupied.
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int ALU_W = 16,
   parameter int MEM_W = 20,   // must be >= ALU_W: ALU results are zero-extended into it
   parameter int OP_W  = 4,
   parameter int RA_W  = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_opcode,
   input  logic [RA_W-1:0]  in_rd,
   input  logic [ALU_W-1:0] in_alu,
   input  logic [MEM_W-1:0] in_mem,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OP_W-1:0]  out_opcode,
   output logic [RA_W-1:0]  out_rd,
   output logic [MEM_W-1:0] out_data,
   output logic             out_we
`ifdef MEM_WB_STATS_EN
   ,
   output logic [31:0]      retired
`endif
);

   typedef struct packed {
      logic [OP_W-1:0]  opcode;
      logic [RA_W-1:0]  rd;
      logic [ALU_W-1:0] alu;
      logic [MEM_W-1:0] mem;
   } entry_t;

   entry_t in_entry;
   entry_t head;

   assign in_entry.opcode = in_opcode;
   assign in_entry.rd     = in_rd;
   assign in_entry.alu    = in_alu;
   assign in_entry.mem    = in_mem;

   skid_buffer2 #(
      .W($bits(entry_t))
   ) u_skid (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head)
   );

   assign out_opcode = head.opcode;
   assign out_rd     = head.rd;

   // Loads write back memory data; every other op writes back the zero-extended ALU result.
   always_comb begin
      out_data = MEM_W'(head.alu);
      if (head.opcode == OP_LOAD) begin
         out_data = head.mem;
      end
   end

   // Register 0 is hardwired, so writes to it are suppressed along with non-writing ops.
   always_comb begin
      out_we = out_valid && is_writeback(head.opcode) && (head.rd != '0);
   end

`ifdef MEM_WB_STATS_EN
   // Count completed write-back handshakes; a handshake in a flush cycle does not count.
   always_ff @(posedge clock) begin
      if (reset) begin
         retired <= 32'd0;
      end else if (out_valid && out_ready && !flush) begin
         retired <= retired + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   localparam int ALU_W = 16;
   localparam int MEM_W = 20;
   localparam int OP_W  = 4;
   localparam int RA_W  = 3;

   logic             clock = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_opcode;
   logic [RA_W-1:0]  in_rd;
   logic [ALU_W-1:0] in_alu;
   logic [MEM_W-1:0] in_mem;
   logic             out_valid;
   logic             out_ready;
   logic [OP_W-1:0]  out_opcode;
   logic [RA_W-1:0]  out_rd;
   logic [MEM_W-1:0] out_data;
   logic             out_we;
`ifdef MEM_WB_STATS_EN
   logic [31:0]      retired;
   logic [31:0]      exp_retired = 32'd0;
`endif

   typedef struct {
      logic [OP_W-1:0]  op;
      logic [RA_W-1:0]  rd;
      logic [MEM_W-1:0] data;
      logic             we;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   started = 1'b0;

   mem_wb_stage #(
      .ALU_W(ALU_W), .MEM_W(MEM_W), .OP_W(OP_W), .RA_W(RA_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_alu     (in_alu),
      .in_mem     (in_mem),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_rd     (out_rd),
      .out_data   (out_data),
      .out_we     (out_we)
`ifdef MEM_WB_STATS_EN
      ,
      .retired    (retired)
`endif
   );

   always #5 clock = ~clock;

   // Reference behaviour straight from the write-back rules.
   function automatic exp_t model(input logic [OP_W-1:0] op, input logic [RA_W-1:0] rd,
                                  input logic [ALU_W-1:0] alu, input logic [MEM_W-1:0] mem);
      exp_t e;
      e.op   = op;
      e.rd   = rd;
      e.data = (op == 4'h2) ? mem : {{(MEM_W-ALU_W){1'b0}}, alu};
      e.we   = !(op == 4'h0 || op == 4'h3 || op == 4'h4) && (rd != 0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Stimulus side: record every accepted entry as its expected write-back.
   always @(negedge clock) begin
      if (started && !reset && !flush && in_valid && in_ready)
         exp_q.push_back(model(in_opcode, in_rd, in_alu, in_mem));
   end

   // Monitor: compare each completed output handshake against the oldest expected entry.
   always @(negedge clock) begin
      if (started) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_opcode", 32'(out_opcode), 32'(e.op));
               check("sb_rd",     32'(out_rd),     32'(e.rd));
               check("sb_data",   32'(out_data),   32'(e.data));
               check("sb_we",     32'(out_we),     32'(e.we));
`ifdef MEM_WB_STATS_EN
               if (!flush && !reset) exp_retired = exp_retired + 32'd1;
`endif
            end
         end
         if (flush || reset) exp_q.delete();
`ifdef MEM_WB_STATS_EN
         if (reset) exp_retired = 32'd0;
`endif
      end
   end

   // Occupancy view: after each edge the stage must mirror the model's queue depth and head.
   always @(posedge clock) begin
      #2;
      if (started) begin
         check("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
         check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            check("head_data", 32'(out_data), 32'(exp_q[0].data));
            check("head_we",   32'(out_we),   32'(exp_q[0].we));
         end else begin
            check("idle_we", 32'(out_we), 32'd0);
         end
`ifdef MEM_WB_STATS_EN
         check("retired", retired, exp_retired);
`endif
      end
   end

   // Apply one cycle of inputs; returns 1 time unit after the edge that sampled them.
   task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [RA_W-1:0] rd,
                        input logic [ALU_W-1:0] alu, input logic [MEM_W-1:0] mem,
                        input logic ordy, input logic fl, input logic rst);
      in_valid  = v;
      in_opcode = op;
      in_rd     = rd;
      in_alu    = alu;
      in_mem    = mem;
      out_ready = ordy;
      flush     = fl;
      reset     = rst;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_opcode = '0; in_rd = '0; in_alu = '0; in_mem = '0;
      @(posedge clock); #1;
      started = 1'b1;
      drive(0, 0, 0, 0, 0, 1, 0, 1);

      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_we",    32'(out_we),    32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_op",    32'(out_opcode), 32'd0);
      check("rst_out_rd",    32'(out_rd),    32'd0);

      // ADD: zero-extended ALU result
      drive(1, 4'h1, 3'd5, 16'h1234, 20'h0, 1, 0, 0);
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_data",  32'(out_data),  32'h01234);
      check("add_we",    32'(out_we),    32'd1);
      // LOAD: memory data
      drive(1, 4'h2, 3'd2, 16'h5555, 20'hABCDE, 1, 0, 0);
      check("load_data", 32'(out_data), 32'hABCDE);
      check("load_we",   32'(out_we),   32'd1);
      // STORE: no write
      drive(1, 4'h3, 3'd3, 16'h0001, 20'h0, 1, 0, 0);
      check("store_valid", 32'(out_valid), 32'd1);
      check("store_we",    32'(out_we),    32'd0);
      // Write to r0: no write
      drive(1, 4'h1, 3'd0, 16'h0002, 20'h0, 1, 0, 0);
      check("r0_we", 32'(out_we), 32'd0);
      drive(0, 0, 0, 0, 0, 1, 0, 0);

      // Back-pressure: A then B with out_ready low
      drive(1, 4'h1, 3'd1, 16'hAAAA, 20'h0, 0, 0, 0);
      drive(1, 4'h1, 3'd2, 16'hBBBB, 20'h0, 0, 0, 0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_head_a",   32'(out_data), 32'h0AAAA);
      drive(1, 4'h1, 3'd3, 16'hCCCC, 20'h0, 0, 0, 0);
      check("bp_hold_a",   32'(out_data), 32'h0AAAA);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      check("bp_head_b",   32'(out_data), 32'h0BBBB);
      check("bp_ready_back", 32'(in_ready), 32'd1);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      check("bp_drained", 32'(out_valid), 32'd0);

      // Flush while FULL with an incoming entry
      drive(1, 4'h1, 3'd1, 16'h1111, 20'h0, 0, 0, 0);
      drive(1, 4'h1, 3'd2, 16'h2222, 20'h0, 0, 0, 0);
      drive(1, 4'h1, 3'd3, 16'h3333, 20'h0, 0, 1, 0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_ready", 32'(in_ready),  32'd1);
      drive(0, 0, 0, 0, 0, 1, 0, 0);

`ifdef MEM_WB_STATS_EN
      drive(0, 0, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 5; i++) drive(1, 4'h1, 3'd1, 16'(i), 20'h0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      check("stats_four", retired, 32'd4);
      drive(0, 0, 0, 0, 0, 1, 0, 1);
      check("stats_reset", retired, 32'd0);
`endif

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 7,
               4'($urandom_range(0, 7)),
               3'($urandom),
               16'($urandom),
               20'($urandom),
               $urandom_range(0, 9) < 6,
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 199) == 0);
      end
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
      check("final_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
